sram_checker: RTL and testbench

- Read-back companion to the SRAM resetter.
- On request, it sweeps every word of an SRAM through port A, reads each one, and compares it against a programmable expected pattern (zero after a reset sweep).
- It counts mismatches, captures the first failing address and data, raises an interrupt when the sweep completes, and holds that interrupt until it is acknowledged.
- It sits beside the resetter on the RX memory and is used for memory self-check after clear.

---
 rtl/sram_checker.sv | 152 +++++++++++++++
 tb/tb_sram_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_checker.sv
// rtl/sram_checker.sv - SRAM read-back checker: sweeps port A and compares every word to a pattern
//
// Purpose: on a rising edge of enable, read every SRAM word through port A and
// compare it with the expected pattern latched at the start of the sweep. The
// checker counts mismatches and captures the first failing address and data.
// When the sweep completes it raises chk_irq and holds it until irq_ack.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          sweep starts on its rising edge; low mid-sweep aborts
//   expected        pattern every word must equal (sampled at sweep start)
//   irq_ack         one-cycle acknowledge of chk_irq
//   ce_a .. addr_a  SRAM port A request side (read-only: we/wmask/wdata are 0)
//   rdata_a         SRAM port A read data, valid RD_LAT cycles after ce_a
//   busy            sweeping or draining outstanding reads
//   chk_irq, pass   sweep complete (level); pass = no mismatches
//   err_count       mismatching words, saturating
//   first_err_addr  address of the first mismatch (0 if none)
//   first_err_data  data read at first_err_addr (0 if none)
module sram_checker #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 512,
  parameter int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DWIDTH-1:0]   expected,
  input  logic                irq_ack,
  output logic                ce_a,
  output logic                we_a,
  output logic [DWIDTH/8-1:0] wmask_a,
  output logic [DWIDTH-1:0]   wdata_a,
  output logic [AWIDTH-1:0]   addr_a,
  input  logic [DWIDTH-1:0]   rdata_a,
  output logic                busy,
  output logic                chk_irq,
  output logic                pass,
  output logic [AWIDTH:0]     err_count,
  output logic [AWIDTH-1:0]   first_err_addr,
  output logic [DWIDTH-1:0]   first_err_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_t            state, state_nxt;
  logic              enable_q;
  logic              start;
  logic              abort;
  logic              issue;
  logic              inflight;
  logic              mismatch;
  logic              err_seen;
  logic [DWIDTH-1:0] exp_q;
  logic [AWIDTH-1:0] addr_q;

  // Outstanding-read tracker: stage RD_LAT-1 is the one whose data is on rdata_a now.
  logic [RD_LAT-1:0] pipe_vld;
  logic [AWIDTH-1:0] pipe_addr [RD_LAT];

  assign start = enable & ~enable_q;
  assign abort = ~enable & ((state == READ) | (state == DRAIN));
  // ce_a is gated by enable so an abort removes the request in the same cycle.
  assign issue = (state == READ) & enable;
  assign mismatch = pipe_vld[RD_LAT-1] & (rdata_a != exp_q);

  // Reads still in flight other than the one being compared this cycle.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) inflight = inflight | pipe_vld[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ: begin
        if (!enable)                state_nxt = IDLE;
        else if (addr_q == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!enable)       state_nxt = IDLE;
        else if (!inflight) state_nxt = DONE;
      end
      DONE:    if (irq_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      enable_q       <= 1'b0;
      exp_q          <= '0;
      addr_q         <= '0;
      err_seen       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pipe_vld       <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      state    <= state_nxt;
      enable_q <= enable;

      if (state == IDLE && start) begin
        exp_q          <= expected;
        addr_q         <= '0;
        err_seen       <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end

      if (state == READ)
        addr_q <= (issue && addr_q != LAST_ADDR) ? addr_q + 1'b1 : '0;

      if (abort) begin
        pipe_vld <= '0;
      end else begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
          pipe_vld[i]  <= pipe_vld[i-1];
          pipe_addr[i] <= pipe_addr[i-1];
        end
        pipe_vld[0]  <= issue;
        pipe_addr[0] <= addr_q;
      end

      if (mismatch && !abort) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!err_seen) begin
          err_seen       <= 1'b1;
          first_err_addr <= pipe_addr[RD_LAT-1];
          first_err_data <= rdata_a;
        end
      end
    end
  end

  assign ce_a    = issue;
  assign we_a    = 1'b0;
  assign wmask_a = '0;
  assign wdata_a = '0;
  assign addr_a  = addr_q;
  assign busy    = (state == READ) | (state == DRAIN);
  assign chk_irq = (state == DONE);
  assign pass    = (state == DONE) & (err_count == '0);

endmodule

// File: tb/tb_sram_checker.sv
// tb/tb_sram_checker.sv - self-checking bench for sram_checker (RD_LAT 1 and 3 instances)
module tb_sram_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en  = 2'b00;
  logic [1:0]  ack = 2'b00;
  logic [31:0] exp_v [2];
  logic [1:0]  ce, we, busy, irq, pass_o;
  logic [3:0]  wm [2];
  logic [31:0] wd [2];
  logic [8:0]  addr [2];
  logic [31:0] rdata [2];
  logic [9:0]  errc [2];
  logic [8:0]  fea [2];
  logic [31:0] fed [2];

  logic [31:0] mem [512];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];

  int checks = 0;
  int failures = 0;
  int cov [512];
  int first1 = -1;
  bit write_seen = 0;

  always #5 clk = ~clk;

  sram_checker #(.DWIDTH(32), .DEPTH(512), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .enable(en[0]), .expected(exp_v[0]), .irq_ack(ack[0]),
    .ce_a(ce[0]), .we_a(we[0]), .wmask_a(wm[0]), .wdata_a(wd[0]), .addr_a(addr[0]),
    .rdata_a(rdata[0]), .busy(busy[0]), .chk_irq(irq[0]), .pass(pass_o[0]),
    .err_count(errc[0]), .first_err_addr(fea[0]), .first_err_data(fed[0]));

  sram_checker #(.DWIDTH(32), .DEPTH(512), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .enable(en[1]), .expected(exp_v[1]), .irq_ack(ack[1]),
    .ce_a(ce[1]), .we_a(we[1]), .wmask_a(wm[1]), .wdata_a(wd[1]), .addr_a(addr[1]),
    .rdata_a(rdata[1]), .busy(busy[1]), .chk_irq(irq[1]), .pass(pass_o[1]),
    .err_count(errc[1]), .first_err_addr(fea[1]), .first_err_data(fed[1]));

  // SRAM models: data appears RD_LAT cycles after the ce_a cycle.
  always @(posedge clk) begin
    rd1    <= ce[0] ? mem[addr[0]] : 32'h0;
    rd3[0] <= ce[1] ? mem[addr[1]] : 32'h0;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign rdata[0] = rd1;
  assign rdata[1] = rd3[2];

  always @(posedge clk) begin
    if (ce[1]) cov[addr[1]]++;
    if (ce[0] && first1 < 0) first1 = int'(addr[0]);
    if ((|we) || (|wm[0]) || (|wm[1]) || (|wd[0]) || (|wd[1])) write_seen = 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the memory image for words that differ from the pattern.
  task automatic ref_model(input logic [31:0] ev, output int cnt, output int fa, output logic [31:0] fd);
    cnt = 0; fa = 0; fd = 32'h0;
    for (int a = 0; a < 512; a++) begin
      if (mem[a] !== ev) begin
        if (cnt == 0) begin fa = a; fd = mem[a]; end
        cnt++;
      end
    end
    if (cnt > 1023) cnt = 1023;
  endtask

  task automatic check_results(input int d, input logic [31:0] ev, input string tag);
    int cnt, fa;
    logic [31:0] fd;
    ref_model(ev, cnt, fa, fd);
    chk({tag, "_irq"},  irq[d], 1);
    chk({tag, "_busy"}, busy[d], 0);
    chk({tag, "_pass"}, pass_o[d], (cnt == 0));
    chk({tag, "_errc"}, errc[d], cnt);
    chk({tag, "_fea"},  fea[d], fa);
    chk({tag, "_fed"},  fed[d], fd);
  endtask

  // Raise enable (low across the previous edge) and count edges until chk_irq.
  task automatic sweep(input int d, input logic [31:0] ev, output int lat);
    exp_v[d] = ev;
    en[d] = 1'b1;
    lat = 0;
    while (!irq[d] && lat < 2000) begin
      step();
      lat++;
    end
  endtask

  task automatic ack_and_drop(input int d);
    ack[d] = 1'b1;
    step();
    ack[d] = 1'b0;
    en[d] = 1'b0;
    step();
  endtask

  task automatic wait_addr(input int d, input int a, input string tag);
    int n = 0;
    while (!(ce[d] && int'(addr[d]) == a) && n < 1000) begin
      step();
      n++;
    end
    chk(tag, (n < 1000), 1);
  endtask

  initial begin
    int lat, cnt1;
    logic [31:0] pat;
    exp_v[0] = 32'h0;
    exp_v[1] = 32'h0;
    for (int a = 0; a < 512; a++) mem[a] = 32'h0;

    // Reset state
    step(); step();
    chk("rst_busy", busy, 2'b00);
    chk("rst_irq", irq, 2'b00);
    chk("rst_pass", pass_o, 2'b00);
    chk("rst_ce", ce, 2'b00);
    chk("rst_addr", addr[0], 0);
    chk("rst_errc", errc[0], 0);
    chk("rst_fea", fea[0], 0);
    chk("rst_fed", fed[0], 0);
    rst = 1'b0;
    step();

    // Cleared memory, RD_LAT=1
    sweep(0, 32'h0, lat);
    chk("clear_latency", lat, 514);
    check_results(0, 32'h0, "clear");
    chk("clear_errc_const", errc[0], 0);
    ack_and_drop(0);

    // Two corrupted words
    mem[37] = 32'hDEAD_BEEF;
    mem[400] = 32'h1;
    sweep(0, 32'h0, lat);
    check_results(0, 32'h0, "two_err");
    chk("two_err_count_const", errc[0], 2);
    chk("two_err_addr_const", fea[0], 37);
    chk("two_err_data_const", fed[0], 32'hDEAD_BEEF);
    ack_and_drop(0);

    // Pattern fill, RD_LAT=3, coverage of addresses and no writes
    for (int a = 0; a < 512; a++) begin mem[a] = 32'hA5A5_A5A5; cov[a] = 0; end
    sweep(1, 32'hA5A5_A5A5, lat);
    chk("pat_latency", lat, 516);
    check_results(1, 32'hA5A5_A5A5, "pat");
    cnt1 = 0;
    for (int a = 0; a < 512; a++) if (cov[a] == 1) cnt1++;
    chk("pat_addr_once", cnt1, 512);
    ack_and_drop(1);

    // Randomized images against the reference model
    for (int i = 0; i < 4; i++) begin
      pat = $urandom;
      for (int a = 0; a < 512; a++) mem[a] = pat;
      if (i == 0) mem[0] = pat ^ 32'h8000_0000;
      for (int k = 0; k < int'($urandom_range(0, 5)); k++)
        mem[$urandom_range(0, 511)] = pat ^ (32'h1 << $urandom_range(0, 31));
      sweep(i % 2, pat, lat);
      chk($sformatf("rand%0d_latency", i), lat, (i % 2) ? 516 : 514);
      check_results(i % 2, pat, $sformatf("rand%0d", i));
      if (i == 0) chk("rand0_errc_nonzero", (errc[0] != 0), 1);
      ack_and_drop(i % 2);
    end

    // Abort at sweep address 100
    for (int a = 0; a < 512; a++) mem[a] = 32'h0;
    en[0] = 1'b1;
    exp_v[0] = 32'h0;
    wait_addr(0, 100, "abort_reach");
    en[0] = 1'b0;
    #1;
    chk("abort_ce_same_cycle", ce[0], 0);
    step();
    chk("abort_busy_next", busy[0], 0);
    repeat (600) step();
    chk("abort_no_irq", irq[0], 0);

    // Restart after abort: full sweep from address 0
    first1 = -1;
    sweep(0, 32'h0, lat);
    chk("restart_latency", lat, 514);
    chk("restart_first_addr", first1, 0);
    check_results(0, 32'h0, "restart");

    // Hold without ack, then ignored start in DONE
    repeat (50) step();
    check_results(0, 32'h0, "hold50");
    en[0] = 1'b0; step();
    en[0] = 1'b1; step(); step();
    chk("done_start_ignored", irq[0], 1);
    chk("done_no_busy", busy[0], 0);

    // Ack with enable held high: back to idle, no restart
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;
    chk("ack_irq_low", irq[0], 0);
    repeat (30) step();
    chk("ack_no_restart_busy", busy[0], 0);
    chk("ack_no_restart_irq", irq[0], 0);
    en[0] = 1'b0;
    step();
    sweep(0, 32'h0, lat);
    chk("toggle_latency", lat, 514);
    ack_and_drop(0);

    // Reset mid-READ at address 200 with a recorded error
    mem[5] = 32'h7;
    en[0] = 1'b1;
    wait_addr(0, 200, "rst_reach");
    chk("pre_rst_errc", errc[0], 1);
    rst = 1'b1;
    en[0] = 1'b0;
    #1;
    chk("midrst_busy", busy[0], 0);
    chk("midrst_ce", ce[0], 0);
    chk("midrst_addr", addr[0], 0);
    chk("midrst_errc", errc[0], 0);
    chk("midrst_fed", fed[0], 0);
    chk("midrst_irq", irq[0], 0);
    step();
    rst = 1'b0;
    step();
    first1 = -1;
    sweep(0, 32'h0, lat);
    chk("post_rst_latency", lat, 514);
    chk("post_rst_first_addr", first1, 0);
    check_results(0, 32'h0, "post_rst");
    ack_and_drop(0);

    chk("never_written", write_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
